// File: rtl/vga_timing_if.sv
// Pixel-path bundle between the raster timing generator and the
// frame pixel generator / panel side.
interface vga_timing_if;
  logic [23:0] pixel_in;
  logic [10:0] vga_h;
  logic [10:0] vga_v;
  logic        frame_start;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [23:0] rgb_out;

  modport master (
    input  pixel_in,
    output vga_h,
    output vga_v,
    output frame_start,
    output hsync,
    output vsync,
    output de,
    output rgb_out
  );

  modport slave (
    output pixel_in,
    input  vga_h,
    input  vga_v,
    input  frame_start,
    input  hsync,
    input  vsync,
    input  de,
    input  rgb_out
  );
endinterface

// File: rtl/vga_timing.sv
// Raster timing generator: free-running h/v counters plus a sync/de
// delay line that lines the timing up with the returned pixel.
module vga_timing #(
  parameter int H_VISIBLE     = 800,
  parameter int H_FRONT       = 40,
  parameter int H_SYNC        = 48,
  parameter int H_BACK        = 40,
  parameter int V_VISIBLE     = 480,
  parameter int V_FRONT       = 13,
  parameter int V_SYNC        = 3,
  parameter int V_BACK        = 29,
  parameter bit HSYNC_POL     = 1'b0,
  parameter bit VSYNC_POL     = 1'b0,
  parameter int PIXEL_LATENCY = 2
) (
  input  logic clk,
  input  logic reset,
  vga_timing_if.master bus
);

  localparam int H_TOTAL =
    H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL =
    V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] LP_H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] LP_V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] LP_H_VIS  = 11'(H_VISIBLE);
  localparam logic [10:0] LP_V_VIS  = 11'(V_VISIBLE);
  localparam logic [10:0] LP_HS_BEG = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] LP_HS_END =
    11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] LP_VS_BEG = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] LP_VS_END =
    11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [10:0] r_h;
  logic [10:0] r_v;
  logic        r_fs;
  logic        w_h_last;
  logic        w_v_last;

  assign w_h_last = (r_h == LP_H_LAST);
  assign w_v_last = (r_v == LP_V_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_h  <= '0;
      r_v  <= '0;
      r_fs <= 1'b0;
    end else begin
      r_fs <= w_h_last && w_v_last;
      if (w_h_last) begin
        r_h <= '0;
        r_v <= w_v_last ? 11'd0 : r_v + 11'd1;
      end else begin
        r_h <= r_h + 11'd1;
      end
    end
  end

  // {vs, hs, de}, all active-high before the output register
  logic [2:0] w_raw;
  logic [2:0] w_tap;

  assign w_raw[0] = (r_h < LP_H_VIS) && (r_v < LP_V_VIS);
  assign w_raw[1] = (r_h >= LP_HS_BEG) && (r_h < LP_HS_END);
  assign w_raw[2] = (r_v >= LP_VS_BEG) && (r_v < LP_VS_END);

  generate
    if (PIXEL_LATENCY == 0) begin : g_nodly
      assign w_tap = w_raw;
    end else begin : g_dly
      logic [2:0] r_dly [PIXEL_LATENCY];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < PIXEL_LATENCY; i++)
            r_dly[i] <= 3'b000;
        end else begin
          r_dly[0] <= w_raw;
          for (int i = 1; i < PIXEL_LATENCY; i++)
            r_dly[i] <= r_dly[i-1];
        end
      end

      assign w_tap = r_dly[PIXEL_LATENCY-1];
    end
  endgenerate

  logic        r_de;
  logic        r_hs;
  logic        r_vs;
  logic [23:0] r_rgb;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_de  <= 1'b0;
      r_hs  <= ~HSYNC_POL;
      r_vs  <= ~VSYNC_POL;
      r_rgb <= '0;
    end else begin
      r_de  <= w_tap[0];
      r_hs  <= w_tap[1] ? HSYNC_POL : ~HSYNC_POL;
      r_vs  <= w_tap[2] ? VSYNC_POL : ~VSYNC_POL;
      r_rgb <= w_tap[0] ? bus.pixel_in : 24'h000000;
    end
  end

  assign bus.vga_h       = r_h;
  assign bus.vga_v       = r_v;
  assign bus.frame_start = r_fs;
  assign bus.hsync       = r_hs;
  assign bus.vsync       = r_vs;
  assign bus.de          = r_de;
  assign bus.rgb_out     = r_rgb;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: full-size, reduced-size and zero-latency
// instances checked every cycle against an arithmetic raster model.
module tb_vga_timing;

  typedef struct {
    int hv, hf, hs, hb, vv, vf, vs, vb, lat;
    bit hp, vp;
  } cfg_t;

  typedef struct {
    logic [10:0] h, v;
    logic        fs, hs, vs, de;
    logic [23:0] rgb;
  } obs_t;

  typedef struct {
    int          inst;
    int          n;
    logic [10:0] h, v;
    logic        hs, vs, de;
    logic [23:0] rgb;
  } vec_t;

  logic clk;
  logic rst_a, rst_b, rst_c;
  int   checks;
  int   failures;

  vga_timing_if u_if_a ();
  vga_timing_if u_if_b ();
  vga_timing_if u_if_c ();

  vga_timing u_dut_a (
    .clk   (clk),
    .reset (rst_a),
    .bus   (u_if_a)
  );

  vga_timing #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6),  .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .PIXEL_LATENCY(2)
  ) u_dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (u_if_b)
  );

  vga_timing #(
    .HSYNC_POL(1'b1),
    .PIXEL_LATENCY(0)
  ) u_dut_c (
    .clk   (clk),
    .reset (rst_c),
    .bus   (u_if_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t model(input cfg_t c, input int n,
                                 input logic [23:0] pprev);
    obs_t e;
    int ht, vt, t, th, tv;
    bit vis, hsa, vsa;
    ht = c.hv + c.hf + c.hs + c.hb;
    vt = c.vv + c.vf + c.vs + c.vb;
    e.h  = 11'(n % ht);
    e.v  = 11'((n / ht) % vt);
    e.fs = (n > 0) && (n % (ht * vt) == 0);
    t = n - c.lat - 1;
    if (t < 0) begin
      e.de = 1'b0; e.hs = ~c.hp; e.vs = ~c.vp; e.rgb = '0;
    end else begin
      th  = t % ht;
      tv  = (t / ht) % vt;
      vis = (th < c.hv) && (tv < c.vv);
      hsa = (th >= c.hv + c.hf) && (th < c.hv + c.hf + c.hs);
      vsa = (tv >= c.vv + c.vf) && (tv < c.vv + c.vf + c.vs);
      e.de  = vis;
      e.hs  = hsa ? c.hp : ~c.hp;
      e.vs  = vsa ? c.vp : ~c.vp;
      e.rgb = vis ? pprev : 24'h000000;
    end
    return e;
  endfunction

  task automatic cmp(input string nm, input int n,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 25)
        $display("FAIL %s n=%0d got=%h want=%h", nm, n, act, exp);
    end
  endtask

  task automatic check_inst(input string nm, input cfg_t c,
                            input int n, input obs_t o,
                            input logic [23:0] pprev);
    obs_t e;
    e = model(c, n, pprev);
    cmp({nm, ".h"},   n, 32'(o.h),   32'(e.h));
    cmp({nm, ".v"},   n, 32'(o.v),   32'(e.v));
    cmp({nm, ".fs"},  n, 32'(o.fs),  32'(e.fs));
    cmp({nm, ".hs"},  n, 32'(o.hs),  32'(e.hs));
    cmp({nm, ".vs"},  n, 32'(o.vs),  32'(e.vs));
    cmp({nm, ".de"},  n, 32'(o.de),  32'(e.de));
    cmp({nm, ".rgb"}, n, 32'(o.rgb), 32'(e.rgb));
  endtask

  initial begin
    cfg_t cfg_a, cfg_b, cfg_c;
    obs_t oa, ob, oc;
    vec_t tbl[$];
    int n_a, n_b, n_c, t2, ht;
    int hs_run_a, de_run_a, hs_run_c;
    logic hs_prev_a, de_prev_a, hs_prev_c;
    int b_seq, c_at, c_len, c_cnt;
    bit b_done, c_done;
    logic [7:0] ph, pv;

    checks = 0; failures = 0;
    cfg_a = '{800, 40, 48, 40, 480, 13, 3, 29, 2, 1'b0, 1'b0};
    cfg_b = '{16, 2, 3, 2, 6, 2, 2, 2, 2, 1'b0, 1'b0};
    cfg_c = '{800, 40, 48, 40, 480, 13, 3, 29, 0, 1'b1, 1'b0};

    tbl.push_back('{0, 0,    11'd0,   11'd0, 1, 1, 0, 24'h0});
    tbl.push_back('{0, 3,    11'd3,   11'd0, 1, 1, 1, 24'h0000A5});
    tbl.push_back('{0, 802,  11'd802, 11'd0, 1, 1, 1, 24'h1F00A5});
    tbl.push_back('{0, 803,  11'd803, 11'd0, 1, 1, 0, 24'h0});
    tbl.push_back('{0, 842,  11'd842, 11'd0, 1, 1, 0, 24'h0});
    tbl.push_back('{0, 843,  11'd843, 11'd0, 0, 1, 0, 24'h0});
    tbl.push_back('{0, 890,  11'd890, 11'd0, 0, 1, 0, 24'h0});
    tbl.push_back('{0, 891,  11'd891, 11'd0, 1, 1, 0, 24'h0});
    tbl.push_back('{0, 928,  11'd0,   11'd1, 1, 1, 0, 24'h0});
    tbl.push_back('{0, 931,  11'd3,   11'd1, 1, 1, 1, 24'h0001A5});
    tbl.push_back('{0, 6504, 11'd8,   11'd7, 1, 1, 1, 24'h0507A5});
    tbl.push_back('{2, 840,  11'd840, 11'd0, 0, 1, 0, 24'h0});
    tbl.push_back('{2, 841,  11'd841, 11'd0, 1, 1, 0, 24'h0});
    tbl.push_back('{2, 888,  11'd888, 11'd0, 1, 1, 0, 24'h0});
    tbl.push_back('{2, 889,  11'd889, 11'd0, 0, 1, 0, 24'h0});

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    u_if_a.pixel_in = 24'hFFFFFF;
    u_if_b.pixel_in = '0;
    u_if_c.pixel_in = '0;
    n_a = 0; n_b = 0; n_c = 0;
    hs_run_a = 0; de_run_a = 0; hs_run_c = 0;
    hs_prev_a = 1'b1; de_prev_a = 1'b0; hs_prev_c = 1'b0;
    b_seq = 0; b_done = 0; c_done = 0; c_cnt = 0;
    c_at  = int'($urandom_range(3000, 2000));
    c_len = int'($urandom_range(3, 1));
    ht = 928;

    repeat (3) @(posedge clk);

    for (int cyc = 0; cyc < 7000; cyc++) begin
      @(posedge clk);
      #1;
      n_a = rst_a ? 0 : n_a + 1;
      n_b = rst_b ? 0 : n_b + 1;
      n_c = rst_c ? 0 : n_c + 1;

      oa = '{u_if_a.vga_h, u_if_a.vga_v, u_if_a.frame_start,
             u_if_a.hsync, u_if_a.vsync, u_if_a.de, u_if_a.rgb_out};
      ob = '{u_if_b.vga_h, u_if_b.vga_v, u_if_b.frame_start,
             u_if_b.hsync, u_if_b.vsync, u_if_b.de, u_if_b.rgb_out};
      oc = '{u_if_c.vga_h, u_if_c.vga_v, u_if_c.frame_start,
             u_if_c.hsync, u_if_c.vsync, u_if_c.de, u_if_c.rgb_out};

      check_inst("a", cfg_a, n_a, oa, u_if_a.pixel_in);
      check_inst("b", cfg_b, n_b, ob, u_if_b.pixel_in);
      check_inst("c", cfg_c, n_c, oc, u_if_c.pixel_in);

      for (int i = 0; i < tbl.size(); i++) begin
        if (tbl[i].inst == 0 && tbl[i].n == n_a && !rst_a) begin
          cmp("tbl.a.h",   n_a, 32'(oa.h),   32'(tbl[i].h));
          cmp("tbl.a.v",   n_a, 32'(oa.v),   32'(tbl[i].v));
          cmp("tbl.a.hs",  n_a, 32'(oa.hs),  32'(tbl[i].hs));
          cmp("tbl.a.vs",  n_a, 32'(oa.vs),  32'(tbl[i].vs));
          cmp("tbl.a.de",  n_a, 32'(oa.de),  32'(tbl[i].de));
          cmp("tbl.a.rgb", n_a, 32'(oa.rgb), 32'(tbl[i].rgb));
        end
        if (tbl[i].inst == 2 && tbl[i].n == n_c && !c_done) begin
          cmp("tbl.c.h",   n_c, 32'(oc.h),   32'(tbl[i].h));
          cmp("tbl.c.hs",  n_c, 32'(oc.hs),  32'(tbl[i].hs));
          cmp("tbl.c.de",  n_c, 32'(oc.de),  32'(tbl[i].de));
          cmp("tbl.c.rgb", n_c, 32'(oc.rgb), 32'(tbl[i].rgb));
        end
      end

      // pulse widths measured directly on the outputs
      if (oa.hs === 1'b0) hs_run_a++;
      else if (hs_prev_a === 1'b0) begin
        cmp("a.hs_width", n_a, 32'(hs_run_a), 32'd48);
        hs_run_a = 0;
      end
      if (oa.de === 1'b1) de_run_a++;
      else if (de_prev_a === 1'b1) begin
        cmp("a.de_width", n_a, 32'(de_run_a), 32'd800);
        de_run_a = 0;
      end
      if (!c_done) begin
        if (oc.hs === 1'b1) hs_run_c++;
        else if (hs_prev_c === 1'b1) begin
          cmp("c.hs_width", n_c, 32'(hs_run_c), 32'd48);
          hs_run_c = 0;
        end
      end
      hs_prev_a = oa.hs; de_prev_a = oa.de; hs_prev_c = oc.hs;

      // reset landed at (19,9), inside both sync pulses
      if (b_seq == 1) begin
        cmp("b.rst.h",  n_b, 32'(ob.h),  32'd0);
        cmp("b.rst.v",  n_b, 32'(ob.v),  32'd0);
        cmp("b.rst.hs", n_b, 32'(ob.hs), 32'd1);
        cmp("b.rst.vs", n_b, 32'(ob.vs), 32'd1);
        cmp("b.rst.de", n_b, 32'(ob.de), 32'd0);
        rst_b = 1'b0;
        b_seq = 2;
      end else if (b_seq >= 2) begin
        cmp("b.post.hs", n_b, 32'(ob.hs), 32'd1);
        cmp("b.post.vs", n_b, 32'(ob.vs), 32'd1);
        b_seq = (b_seq == 4) ? 0 : b_seq + 1;
      end

      if (cyc == 0) begin
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      end
      if (!b_done && n_b == 778 && !rst_b) begin
        rst_b = 1'b1; b_done = 1; b_seq = 1;
      end
      if (c_done && rst_c) begin
        c_cnt--;
        if (c_cnt == 0) rst_c = 1'b0;
      end else if (!c_done && n_c == c_at) begin
        rst_c = 1'b1; c_done = 1; c_cnt = c_len;
      end

      t2 = n_a - 2;
      if (t2 >= 0 && (t2 % ht) < 800 && ((t2 / ht) % 525) < 480) begin
        ph = 8'((t2 % ht) & 255);
        pv = 8'(((t2 / ht) % 525) & 255);
        u_if_a.pixel_in = {ph, pv, 8'hA5};
      end else begin
        u_if_a.pixel_in = 24'hFFFFFF;
      end
      u_if_b.pixel_in = 24'($urandom);
      u_if_c.pixel_in = 24'($urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Raster timing generator for the 800x480 VGA/LCD output path.
- Free-running horizontal and vertical counters drive vga_h/vga_v to the frame pixel generator.
- The generator returns a 24-bit pixel value a fixed number of cycles later. This block aligns hsync/vsync/de with that returned pixel and drives the blanked RGB output to the panel.
- It is the consumer end of the vga_h/vga_v -> pixel interface.

Parameters:
- H_VISIBLE, 800, active pixels per line
- H_FRONT, 40, horizontal front porch (clocks)
- H_SYNC, 48, hsync pulse width (clocks)
- H_BACK, 40, horizontal back porch (clocks); H_TOTAL = sum = 928
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 13, vertical front porch (lines)
- V_SYNC, 3, vsync pulse width (lines)
- V_BACK, 29, vertical back porch (lines); V_TOTAL = sum = 525
- HSYNC_POL, 0, active level of hsync (0 = active-low)
- VSYNC_POL, 0, active level of vsync
- PIXEL_LATENCY, 2, clocks from vga_h/vga_v to the matching pixel_in (legal 0..7)

Ports:
- clk  input  1  pixel clock
- reset  input  1  synchronous, active-high reset
- pixel_in  input  24  RGB from pixel generator, {R[23:16],G[15:8],B[7:0]}
- vga_h  output  11  current horizontal count, 0..H_TOTAL-1
- vga_v  output  11  current vertical count, 0..V_TOTAL-1
- frame_start  output  1  one-cycle pulse when counters wrap to (0,0)
- hsync  output  1  horizontal sync, aligned to rgb_out
- vsync  output  1  vertical sync, aligned to rgb_out
- de  output  1  data enable (visible area), aligned to rgb_out
- rgb_out  output  24  pixel to panel; zero outside the visible area

Behaviour:
- One clock domain, `clk`. Reset is synchronous and active-high on `reset`. All outputs are registered.
- Reset values:
  - vga_h = 0, vga_v = 0, frame_start = 0, de = 0, rgb_out = 0
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL
  - every delay-line stage cleared to the inactive values above
- While reset is held, the counters stay at (0,0).
- Counters:
  - Each cycle out of reset, vga_h increments.
  - When vga_h == H_TOTAL-1, vga_h wraps to 0 and vga_v increments.
  - When vga_v == V_TOTAL-1 at that same point, vga_v also wraps to 0.
  - Frame period = H_TOTAL*V_TOTAL = 487200 clocks.
- frame_start is 1 only in the cycle where the counters show (0,0) reached by wrapping from (H_TOTAL-1, V_TOTAL-1). The (0,0) state held during and just after reset is not flagged.
- Raw timing, decoded from the counter values:
  - de_raw = (h < H_VISIBLE) && (v < V_VISIBLE)
  - hs_raw active when H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC (840..887)
  - vs_raw active when V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC (493..495)
  - vsync is line-based: it changes only on the cycle vga_h returns to 0.
- Alignment:
  - pixel_in for counter cycle t arrives at cycle t+PIXEL_LATENCY.
  - de_raw, hs_raw and vs_raw pass through a PIXEL_LATENCY-stage shift register, then one output register.
  - rgb_out, de, hsync and vsync for counter cycle t all appear at cycle t+PIXEL_LATENCY+1.
  - rgb_out = delayed de ? pixel_in : 24'h000000.
  - Sync outputs apply the polarity parameters at the output register.
- PIXEL_LATENCY = 0: no shift stages; only the output register remains (1-cycle alignment).
- Reset mid-frame: the next edge forces counters to (0,0) and flushes the delay line. No sync or de pulse from the aborted frame may emerge after reset deasserts.
- Widths: counters are 11 bits. Parameter sums must stay below 2048; out-of-range counts never occur.

Test Plan:
- Release reset, run 2 frames, PIXEL_LATENCY=2:
  - vga_h cycles 0..927
  - vga_v cycles 0..524
  - frame_start pulses exactly once per 487200 clocks, at (0,0)
- Line timing: hsync low for exactly 48 clocks. Its first low cycle is 3 clocks after vga_h==840 (latency+1). de is high for 800 consecutive clocks per visible line.
- Frame timing:
  - vsync low for exactly 3*928 clocks, starting 3 clocks after (h=0, v=493)
  - de stays 0 for lines 480..524
- Alignment: drive pixel_in = {vga_h[7:0],vga_v[7:0],8'hA5}, delayed 2 clocks by a bench model.
  - Pixel (5,7) must appear on rgb_out = 24'h0507A5 in the same cycle de is high.
  - rgb_out = 0 whenever de = 0, even with pixel_in = 24'hFFFFFF.
- Reset at (h=850, v=494), during both hsync and vsync, held 1 cycle:
  - next cycle: counters (0,0), hsync = vsync = 1, de = 0
  - no stale sync pulses on the following 3 cycles
- Polarity and zero latency: HSYNC_POL=1, PIXEL_LATENCY=0.
  - hsync is high for 48 clocks, starting 1 clock after vga_h==840.
  - rgb_out tracks pixel_in with 1-cycle latency.
